omem_write_drain: RTL

Output-memory write drain that sits directly downstream of the execution unit's IO station write port. Captures each 96-bit OMEM row write (address + X/Y/Z data) into a small FIFO and serialises it as three 32-bit word writes on a valid/ready port toward external output memory. The execution unit has no stall input, so rows arriving while the FIFO is full are dropped and flagged with a sticky overflow bit.

---
 rtl/omem_write_drain_pkg.sv | 43 ++++
 rtl/omem_row_fifo.sv | 65 ++++++
 rtl/omem_write_drain.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/omem_write_drain_pkg.sv
// Shared definitions for the OMEM write drain: row/word geometry,
// component indices and the serialiser state encoding.
package omem_write_drain_pkg;

    localparam int DATA_ROW_WIDTH = 96;
    localparam int WORD_WIDTH     = 32;
    localparam int COMP_WIDTH     = 32;
    localparam int NUM_COMPS      = 3;

    // Only the low 30 bits of a row address are meaningful; the word
    // address appends the 2-bit component index below them.
    localparam int ROW_ADDR_BITS  = 30;
    localparam int COMP_IDX_BITS  = 2;

    // Component bit ranges inside a data row.
    localparam int COMP_X_MSB = 95;
    localparam int COMP_X_LSB = 64;
    localparam int COMP_Y_MSB = 63;
    localparam int COMP_Y_LSB = 32;
    localparam int COMP_Z_MSB = 31;
    localparam int COMP_Z_LSB = 0;

    localparam logic [COMP_IDX_BITS-1:0] COMP_X = 2'd0;
    localparam logic [COMP_IDX_BITS-1:0] COMP_Y = 2'd1;
    localparam logic [COMP_IDX_BITS-1:0] COMP_Z = 2'd2;

    // One FIFO entry carries the used address bits plus the full data row.
    localparam int ENTRY_WIDTH = ROW_ADDR_BITS + DATA_ROW_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drainState_t;

    // External word address = {row address, component index}.
    function automatic logic [WORD_WIDTH-1:0] makeWordAddress(
        input logic [ROW_ADDR_BITS-1:0] rowAddr,
        input logic [COMP_IDX_BITS-1:0] comp
    );
        return {rowAddr, comp};
    endfunction

endpackage

// File: rtl/omem_row_fifo.sv
// Small synchronous row FIFO. Head entry is read asynchronously so the
// serialiser can load it on the same edge as the pop (no read bubble);
// at this depth the array maps to distributed RAM.
module omem_row_fifo #(
    parameter int WIDTH = 126,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] DEPTH_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;

    assign full    = (countReg == DEPTH_COUNT);
    assign empty   = (countReg == '0);
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign doPush  = push & (~full | pop);
    assign doPop   = pop & ~empty;
    assign popData = mem[rdPtrReg];
    assign count   = countReg;

    // Storage array write; contents need no reset since pointers gate reads.
    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + AW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (AW + 1)'(1);
                2'b01:   countReg <= countReg - (AW + 1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/omem_write_drain.sv
// OMEM write drain: buffers 96-bit row writes from the IO station and
// serialises each as X, Y, Z word writes on a valid/ready port. The
// upstream cannot stall, so rows arriving into a full FIFO are dropped
// and recorded in a sticky overflow flag.
module omem_write_drain
    import omem_write_drain_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [DATA_ROW_WIDTH-1:0] iOMEMWriteAddress,
    input  logic [DATA_ROW_WIDTH-1:0] iOMEMWriteData,
    input  logic                      iOMEMWriteEnable,
    output logic                      oWordValid,
    input  logic                      iWordReady,
    output logic [WORD_WIDTH-1:0]     oWordAddress,
    output logic [WORD_WIDTH-1:0]     oWordData,
    output logic [FIFO_AW:0]          oFifoCount,
    output logic                      oOverflow,
    input  logic                      iClearOverflow,
    output logic                      oIdle
);

    drainState_t              stateReg;
    drainState_t              stateNext;
    logic [COMP_IDX_BITS-1:0] compReg;
    logic [COMP_IDX_BITS-1:0] compNext;
    logic [ROW_ADDR_BITS-1:0] holdAddrReg;
    logic [DATA_ROW_WIDTH-1:0] holdDataReg;
    logic                     overflowReg;

    logic                     fifoPop;
    logic [ENTRY_WIDTH-1:0]   fifoPushData;
    logic [ENTRY_WIDTH-1:0]   fifoPopData;
    logic [FIFO_AW:0]         fifoCount;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     dropRow;
    logic [COMP_WIDTH-1:0]    compWord [4];

    // Upper row-address bits carry no meaning for the external memory.
    logic unusedAddrBits;
    assign unusedAddrBits = ^iOMEMWriteAddress[DATA_ROW_WIDTH-1:ROW_ADDR_BITS];

    assign fifoPushData = {iOMEMWriteAddress[ROW_ADDR_BITS-1:0], iOMEMWriteData};

    omem_row_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) uRowFifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (iOMEMWriteEnable),
        .pushData (fifoPushData),
        .pop      (fifoPop),
        .popData  (fifoPopData),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Slice the held row into components; index 3 is unused and reads zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gCompSlice
            if (gi < NUM_COMPS) begin : gComp
                assign compWord[gi] = holdDataReg[DATA_ROW_WIDTH-1-gi*COMP_WIDTH -: COMP_WIDTH];
            end else begin : gPad
                assign compWord[gi] = '0;
            end
        end
    endgenerate

    // Serialiser next-state: load a row when idle, step X->Y->Z, and chain
    // straight into the next buffered row after Z to avoid a bubble.
    always_comb begin
        stateNext = stateReg;
        compNext  = compReg;
        fifoPop   = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    compNext  = COMP_X;
                    stateNext = ST_SEND;
                end
            end
            ST_SEND: begin
                if (iWordReady) begin
                    if (compReg != COMP_Z) begin
                        compNext = compReg + 2'd1;
                    end else if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        compNext = COMP_X;
                    end else begin
                        compNext  = COMP_X;
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
                compNext  = COMP_X;
            end
        endcase
    end

    // A row is lost only when the FIFO is full and nothing leaves this cycle.
    assign dropRow = iOMEMWriteEnable & fifoFull & ~fifoPop;

    // Serialiser state and component counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg <= ST_IDLE;
            compReg  <= COMP_X;
        end else begin
            stateReg <= stateNext;
            compReg  <= compNext;
        end
    end

    // Holding register captures the FIFO head on every pop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            holdAddrReg <= '0;
            holdDataReg <= '0;
        end else if (fifoPop) begin
            holdAddrReg <= fifoPopData[ENTRY_WIDTH-1:DATA_ROW_WIDTH];
            holdDataReg <= fifoPopData[DATA_ROW_WIDTH-1:0];
        end
    end

    // Sticky overflow; a drop in the same cycle wins over a clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflowReg <= 1'b0;
        end else if (dropRow) begin
            overflowReg <= 1'b1;
        end else if (iClearOverflow) begin
            overflowReg <= 1'b0;
        end
    end

    assign oWordValid   = (stateReg == ST_SEND);
    assign oWordAddress = makeWordAddress(holdAddrReg, compReg);
    assign oWordData    = compWord[compReg];
    assign oFifoCount   = fifoCount;
    assign oOverflow    = overflowReg;
    assign oIdle        = (stateReg == ST_IDLE) & fifoEmpty;

endmodule
